// File: rtl/rocketcpu_uart_wbmaster_if.sv
// Wishbone initiator-side bundle for the serial debug bridge.
// The master drives address/data/strobes and the slave answers with read data and ack.
interface rocketcpu_uart_wbmaster_if;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack
    );
endinterface

// File: rtl/rocketcpu_uart_wbmaster.sv
// Serial-to-Wishbone debug bridge: 8N1 command frames in, a single 32-bit bus cycle,
// then a status byte or four read-data bytes back out on the serial line.
module rocketcpu_uart_wbmaster #(
    parameter int CLKDIV  = 104,
    parameter int TIMEOUT = 1024
) (
    input  logic i_wb_clk,
    input  logic resetn,
    input  logic ser_rx,
    output logic ser_tx,
    output logic o_busy,
    rocketcpu_uart_wbmaster_if.master wb
);
    localparam int CW = $clog2(CLKDIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    logic [1:0]    rxSync_q;
    logic          rxPrev_q;
    logic          rxBusy_q;
    logic [CW-1:0] rxCnt_q;
    logic [3:0]    rxBit_q;
    logic [7:0]    rxShift_q;
    logic          rxValid_q;
    logic [7:0]    rxByte_q;

    state_t        state_q;
    logic          isWrite_q;
    logic          wbWe_q;
    logic          cyc_q;
    logic [3:0]    sel_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [1:0]    byteCnt_q;
    logic [TW-1:0] toCnt_q;
    logic [31:0]   resp_q;
    logic [1:0]    respLeft_q;
    logic [9:0]    txFrame_q;
    logic [CW-1:0] txCnt_q;
    logic [3:0]    txBit_q;

    // Receiver: start bit re-checked at mid-bit so short glitches are dropped; bad stop bits discard the byte.
    always_ff @(posedge i_wb_clk) begin
        if (!resetn) begin
            rxSync_q  <= 2'b11;
            rxPrev_q  <= 1'b1;
            rxBusy_q  <= 1'b0;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            rxValid_q <= 1'b0;
            rxByte_q  <= '0;
        end else begin
            rxSync_q  <= {rxSync_q[0], ser_rx};
            rxPrev_q  <= rxSync_q[1];
            rxValid_q <= 1'b0;
            if (!rxBusy_q) begin
                if (rxPrev_q && !rxSync_q[1]) begin
                    rxBusy_q <= 1'b1;
                    rxCnt_q  <= HALF_LAST;
                    rxBit_q  <= '0;
                end
            end else if (rxCnt_q != '0) begin
                rxCnt_q <= rxCnt_q - 1'b1;
            end else begin
                rxCnt_q <= BIT_LAST;
                if (rxBit_q == 4'd0) begin
                    if (rxSync_q[1]) rxBusy_q <= 1'b0;
                    else             rxBit_q  <= 4'd1;
                end else if (rxBit_q == 4'd9) begin
                    rxBusy_q <= 1'b0;
                    if (rxSync_q[1]) begin
                        rxValid_q <= 1'b1;
                        rxByte_q  <= rxShift_q;
                    end
                end else begin
                    rxShift_q <= {rxSync_q[1], rxShift_q[7:1]};
                    rxBit_q   <= rxBit_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            isWrite_q  <= 1'b0;
            wbWe_q     <= 1'b0;
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            byteCnt_q  <= '0;
            toCnt_q    <= '0;
            resp_q     <= '0;
            respLeft_q <= '0;
            txFrame_q  <= '1;
            txCnt_q    <= '0;
            txBit_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rxValid_q && (rxByte_q == 8'h57 || rxByte_q == 8'h52)) begin
                        isWrite_q <= (rxByte_q == 8'h57);
                        byteCnt_q <= '0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (rxValid_q) begin
                        adr_q     <= {adr_q[23:0], rxByte_q};
                        byteCnt_q <= byteCnt_q + 1'b1;
                        if (byteCnt_q == 2'd3) begin
                            if (isWrite_q) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= BUS;
                                cyc_q   <= 1'b1;
                                sel_q   <= 4'hF;
                                wbWe_q  <= 1'b0;
                                toCnt_q <= '0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rxValid_q) begin
                        dat_q     <= {dat_q[23:0], rxByte_q};
                        byteCnt_q <= byteCnt_q + 1'b1;
                        if (byteCnt_q == 2'd3) begin
                            state_q <= BUS;
                            cyc_q   <= 1'b1;
                            sel_q   <= 4'hF;
                            wbWe_q  <= 1'b1;
                            toCnt_q <= '0;
                        end
                    end
                end
                // Ack is tested before the timeout so a same-edge collision reports success.
                BUS: begin
                    if (wb.i_wb_ack || toCnt_q == TO_LAST) begin
                        cyc_q   <= 1'b0;
                        sel_q   <= '0;
                        wbWe_q  <= 1'b0;
                        txCnt_q <= BIT_LAST;
                        txBit_q <= '0;
                        state_q <= RESP;
                        if (wb.i_wb_ack && !isWrite_q) begin
                            txFrame_q  <= {1'b1, wb.i_wb_rdt[31:24], 1'b0};
                            resp_q     <= {wb.i_wb_rdt[23:0], 8'h00};
                            respLeft_q <= 2'd3;
                        end else begin
                            txFrame_q  <= {1'b1, (wb.i_wb_ack ? 8'h4B : 8'h45), 1'b0};
                            respLeft_q <= '0;
                        end
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                // The next byte's start bit replaces the stop bit's last cycle boundary, so bytes run back to back.
                RESP: begin
                    if (txCnt_q != '0) begin
                        txCnt_q <= txCnt_q - 1'b1;
                    end else begin
                        txCnt_q <= BIT_LAST;
                        if (txBit_q == 4'd9) begin
                            if (respLeft_q != '0) begin
                                txFrame_q  <= {1'b1, resp_q[31:24], 1'b0};
                                resp_q     <= {resp_q[23:0], 8'h00};
                                respLeft_q <= respLeft_q - 1'b1;
                                txBit_q    <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            txFrame_q <= {1'b1, txFrame_q[9:1]};
                            txBit_q   <= txBit_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ser_tx      = txFrame_q[0];
    assign o_busy      = (state_q != IDLE);
    assign wb.o_wb_adr = adr_q;
    assign wb.o_wb_dat = dat_q;
    assign wb.o_wb_sel = sel_q;
    assign wb.o_wb_we  = wbWe_q;
    assign wb.o_wb_cyc = cyc_q;
endmodule

// File: tb/tb_rocketcpu_uart_wbmaster.sv
// Directed bench for the serial Wishbone bridge: a vector table of complete commands plus
// hand-written sequences for junk/framing bytes and a mid-cycle reset.
module tb_rocketcpu_uart_wbmaster;
    localparam int CLKDIV  = 16;
    localparam int TIMEOUT = 32;

    typedef struct {
        logic [71:0] cmd;
        int          nCmd;
        int          ackDelay;
        logic [31:0] rdt;
        logic [31:0] expAdr;
        logic [31:0] expDat;
        logic        expWe;
        int          expCycLen;
        logic [31:0] resp;
        int          nResp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic serRx = 1'b1;
    logic serTx;
    logic busy;

    rocketcpu_uart_wbmaster_if wbIf ();

    rocketcpu_uart_wbmaster #(.CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
        .i_wb_clk (clk),
        .resetn   (resetn),
        .ser_rx   (serRx),
        .ser_tx   (serTx),
        .o_busy   (busy),
        .wb       (wbIf)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;

    int          curAckDelay = 0;
    logic [31:0] curRdt = '0;
    int          busCycles = 0;
    int          cycLen = 0;
    logic        prevCyc = 1'b0;
    logic        unstable = 1'b0;
    logic [31:0] seenAdr, seenDat;
    logic [3:0]  seenSel;
    logic        seenWe;

    logic [7:0] rxQ[$];
    int         startQ[$];

    vec_t vecs[6];
    vec_t junkRead, postReset;

    always @(posedge clk) cycleNo++;

    // Bus slave: records the cycle it sees and acks on the requested cycle count.
    always @(negedge clk) begin
        if (wbIf.o_wb_cyc === 1'b1) begin
            if (!prevCyc) begin
                busCycles++;
                cycLen  = 0;
                seenAdr = wbIf.o_wb_adr;
                seenDat = wbIf.o_wb_dat;
                seenSel = wbIf.o_wb_sel;
                seenWe  = wbIf.o_wb_we;
            end else if (seenAdr !== wbIf.o_wb_adr || seenDat !== wbIf.o_wb_dat ||
                         seenSel !== wbIf.o_wb_sel || seenWe !== wbIf.o_wb_we) begin
                unstable = 1'b1;
            end
            cycLen++;
            if (curAckDelay != 0 && cycLen == curAckDelay) begin
                wbIf.i_wb_ack = 1'b1;
                wbIf.i_wb_rdt = curRdt;
            end else begin
                wbIf.i_wb_ack = 1'b0;
                wbIf.i_wb_rdt = '0;
            end
            prevCyc = 1'b1;
        end else begin
            wbIf.i_wb_ack = 1'b0;
            wbIf.i_wb_rdt = '0;
            prevCyc = 1'b0;
        end
    end

    // Serial receiver for the response line.
    initial begin
        logic [7:0] b;
        int startC;
        forever begin
            @(negedge serTx);
            startC = cycleNo;
            repeat (CLKDIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLKDIV) @(negedge clk);
                b[i] = serTx;
            end
            repeat (CLKDIV) @(negedge clk);
            rxQ.push_back(b);
            startQ.push_back(startC);
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t makeVec(logic [71:0] cmd, int nCmd, int ackDelay, logic [31:0] rdt,
                                     logic [31:0] expAdr, logic [31:0] expDat, logic expWe,
                                     int expCycLen, logic [31:0] resp, int nResp);
        vec_t v;
        v.cmd = cmd; v.nCmd = nCmd; v.ackDelay = ackDelay; v.rdt = rdt;
        v.expAdr = expAdr; v.expDat = expDat; v.expWe = expWe;
        v.expCycLen = expCycLen; v.resp = resp; v.nResp = nResp;
        return v;
    endfunction

    function automatic void checkValue(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic stopVal);
        @(negedge clk);
        serRx = 1'b0;
        repeat (CLKDIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serRx = b[i];
            repeat (CLKDIV) @(negedge clk);
        end
        serRx = stopVal;
        repeat (CLKDIV) @(negedge clk);
        serRx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic done;
        curAckDelay = v.ackDelay;
        curRdt      = v.rdt;
        rxQ.delete();
        startQ.delete();
        busCycles = 0;
        unstable  = 1'b0;
        cycLen    = 0;
        for (int i = 0; i < v.nCmd; i++) sendByte(v.cmd[8*(v.nCmd-1-i) +: 8], 1'b1);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (rxQ.size() >= v.nResp && !busy) done = 1'b1;
        end
        if (!done) checkValue("respWait", 32'(done), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue("busCycles", 32'(busCycles), 32'd1);
        checkValue("adr", seenAdr, v.expAdr);
        checkValue("we", 32'(seenWe), 32'(v.expWe));
        checkValue("sel", 32'(seenSel), 32'hF);
        if (v.expWe) checkValue("dat", seenDat, v.expDat);
        checkValue("cycLen", 32'(cycLen), 32'(v.expCycLen));
        checkValue("stable", 32'(unstable), 32'd0);
        checkValue("respCount", 32'(rxQ.size()), 32'(v.nResp));
        for (int i = 0; i < v.nResp && i < rxQ.size(); i++)
            checkValue("respByte", 32'(rxQ[i]), 32'(v.resp[8*(v.nResp-1-i) +: 8]));
        for (int i = 1; i < startQ.size(); i++)
            checkValue("respGap", 32'(startQ[i] - startQ[i-1]), 32'(10 * CLKDIV));
        checkValue("busyIdle", 32'(busy), 32'd0);
        checkValue("txIdle", 32'(serTx), 32'd1);
        checkValue("cycIdle", 32'(wbIf.o_wb_cyc), 32'd0);
    endtask

    initial begin
        logic [39:0] midCmd;
        logic sawCyc;

        vecs[0] = makeVec(72'h57_00001000_DEADBEEF, 9, 3, 32'h0,
                          32'h00001000, 32'hDEADBEEF, 1'b1, 3, 32'h4B, 1);
        vecs[1] = makeVec(72'h52_80000004, 5, 2, 32'h12345678,
                          32'h80000004, 32'h0, 1'b0, 2, 32'h12345678, 4);
        vecs[2] = makeVec(72'h52_00000000, 5, 0, 32'h0,
                          32'h00000000, 32'h0, 1'b0, TIMEOUT, 32'h45, 1);
        vecs[3] = makeVec(72'h57_12345678_00000001, 9, 1, 32'h0,
                          32'h12345678, 32'h00000001, 1'b1, 1, 32'h4B, 1);
        vecs[4] = makeVec(72'h52_00000008, 5, TIMEOUT, 32'hA5A50FF0,
                          32'h00000008, 32'h0, 1'b0, TIMEOUT, 32'hA5A50FF0, 4);
        vecs[5] = makeVec(72'h57_FFFFFFFC_00000000, 9, TIMEOUT, 32'h0,
                          32'hFFFFFFFC, 32'h00000000, 1'b1, TIMEOUT, 32'h4B, 1);
        junkRead  = makeVec(72'h52_00000010, 5, 1, 32'hCAFEBABE,
                            32'h00000010, 32'h0, 1'b0, 1, 32'hCAFEBABE, 4);
        postReset = makeVec(72'h57_00000040_CAFEF00D, 9, 4, 32'h0,
                            32'h00000040, 32'hCAFEF00D, 1'b1, 4, 32'h4B, 1);

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkValue("rstTx", 32'(serTx), 32'd1);
        checkValue("rstCyc", 32'(wbIf.o_wb_cyc), 32'd0);
        checkValue("rstWe", 32'(wbIf.o_wb_we), 32'd0);
        checkValue("rstSel", 32'(wbIf.o_wb_sel), 32'd0);
        checkValue("rstAdr", wbIf.o_wb_adr, 32'd0);
        checkValue("rstDat", wbIf.o_wb_dat, 32'd0);
        checkValue("rstBusy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Unknown opcode, then a write opcode with a broken stop bit: neither may start anything.
        rxQ.delete();
        busCycles = 0;
        sendByte(8'h41, 1'b1);
        sendByte(8'h57, 1'b0);
        repeat (2 * CLKDIV) @(negedge clk);
        checkValue("junkBus", 32'(busCycles), 32'd0);
        checkValue("junkBusy", 32'(busy), 32'd0);
        checkValue("junkResp", 32'(rxQ.size()), 32'd0);
        applyStimulus(junkRead);
        checkOutput(junkRead);

        // Reset while the bus cycle is outstanding: everything drops and nothing is sent.
        curAckDelay = 0;
        busCycles = 0;
        midCmd = 40'h52_00000020;
        for (int i = 0; i < 5; i++) sendByte(midCmd[8*(4-i) +: 8], 1'b1);
        sawCyc = 1'b0;
        for (int c = 0; c < 100 && !sawCyc; c++) begin
            @(negedge clk);
            if (wbIf.o_wb_cyc === 1'b1) sawCyc = 1'b1;
        end
        checkValue("midCycSeen", 32'(sawCyc), 32'd1);
        repeat (5) @(negedge clk);
        checkValue("midBusy", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkValue("midRstCyc", 32'(wbIf.o_wb_cyc), 32'd0);
        checkValue("midRstTx", 32'(serTx), 32'd1);
        checkValue("midRstBusy", 32'(busy), 32'd0);
        checkValue("midRstSel", 32'(wbIf.o_wb_sel), 32'd0);
        rxQ.delete();
        repeat (20 * CLKDIV) @(negedge clk);
        checkValue("midNoResp", 32'(rxQ.size()), 32'd0);
        applyStimulus(postReset);
        checkOutput(postReset);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/rocketcpu_uart_wbmaster.md
Name: rocketcpu_uart_wbmaster

Overview:
- Serial debug bridge: receives 8N1 command frames on ser_rx and issues single 32-bit Wishbone cycles as bus initiator.
- Returns status or read data on ser_tx.
- Sits beside the CPU as a second bus master for host-side memory/peripheral poke and peek, through an external arbiter.
- Complement of the CPU-side UART slave: the host drives the bus instead of the CPU.

Parameters:
- CLKDIV, 104, clock cycles per serial bit (integer, >= 4).
- TIMEOUT, 1024, max cycles o_wb_cyc may stay high without i_wb_ack before abort (>= 2).

Ports:
- i_wb_clk  input  1  system/bus clock, all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- ser_rx  input  1  serial in, asynchronous, idle high.
- ser_tx  output  1  serial out, idle high.
- o_wb_adr  output  32  bus address.
- o_wb_dat  output  32  write data.
- o_wb_sel  output  4  byte lanes, always 4'hF during a cycle, 0 otherwise.
- o_wb_we  output  1  write enable.
- o_wb_cyc  output  1  cycle/strobe (combined; no separate stb).
- i_wb_rdt  input  32  read data, valid with ack.
- i_wb_ack  input  1  cycle acknowledge.
- o_busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (resetn low at a clock edge): FSM to IDLE; ser_tx=1; o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_busy=0; RX/TX shifters, byte counters and timeout counter cleared.
- Reset mid-operation: an in-flight bus cycle is dropped immediately, a partial TX byte is truncated (line forced high), and no response is sent.
- RX:
  - ser_rx passes through a 2-flop synchronizer.
  - Falling edge while idle starts a frame; the start bit is re-checked at CLKDIV/2. If it is high there, it is a glitch: ignore it.
  - Data bits sampled every CLKDIV after that, LSB first. Stop bit sampled likewise.
  - Stop=0 is a framing error: discard the byte, no FSM effect.
  - Valid byte produces a 1-cycle rx_valid strobe.
- TX: 8N1, LSB first, each bit held exactly CLKDIV cycles. Back-to-back response bytes have no idle gap beyond the stop bit.
- Protocol (multi-byte fields MSB first):
  - Write: 0x57, A3..A0, D3..D0 -> response 0x4B on ack, 0x45 on timeout.
  - Read: 0x52, A3..A0 -> response D3..D0 from i_wb_rdt on ack, single 0x45 on timeout.
  - Any other first byte is ignored and the FSM stays in IDLE.
- FSM states:
  - IDLE: rx_valid with 0x57/0x52 latches we and goes to ADDR.
  - ADDR: shift 4 bytes into the address register. After the 4th: read goes to BUS, write goes to DATA.
  - DATA: shift 4 bytes into the data register, then BUS.
  - BUS: o_wb_cyc=1, o_wb_sel=F, o_wb_we per command; adr/dat stable for the whole cycle.
    - Cycle asserted the clock after the last command byte's rx_valid.
    - Timeout counter starts at 0 and increments each cycle cyc=1.
    - i_wb_ack=1 at an edge: capture i_wb_rdt, deassert cyc/we/sel at that same edge, go to RESP(ok). Latency: cyc high >= 1 cycle.
    - Counter reaching TIMEOUT-1 without ack: deassert cyc, go to RESP(err). Cycle length is exactly TIMEOUT.
    - Ack on the same edge as the timeout: ack wins.
  - RESP: transmit 1 byte (write ok / any err) or 4 bytes (read ok). After the final stop bit: IDLE.
- RX bytes arriving in BUS or RESP are discarded. There is no inter-byte timeout in ADDR/DATA.
- i_wb_ack while cyc=0 is ignored.

Test Plan (CLKDIV=16, TIMEOUT=32):
- Write: send 57 00 00 10 00 DE AD BE EF; slave acks 3 cycles after cyc -> one cycle with adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; cyc high exactly 3 cycles; ser_tx returns 0x4B.
- Read: send 52 80 00 00 04; slave acks with rdt=0x12345678 -> cycle with we=0, adr=0x80000004; ser_tx returns 12 34 56 78 back-to-back; o_busy low after the last stop bit.
- Timeout: read 52 00 00 00 00 with no ack -> cyc high exactly 32 cycles, then ser_tx returns 0x45 only. A following valid command works normally.
- Junk/framing: send 0x41, then a 0x57 byte with stop bit=0, then a valid read -> no bus activity from the first two; the read completes normally.
- Ack/timeout collision: ack on cycle 32 -> 0x4B/data response, not 0x45.
- Reset mid-op: assert resetn=0 for 1 cycle while cyc=1 -> cyc=0 and ser_tx=1 the next cycle, no response byte, o_busy=0; a subsequent write succeeds.
